spi_master: RTL
===============

# spi_master

Master end of the single-wire-command SPI link that feeds the SPI slave / single-port RAM wrapper. Accepts one command per handshake from a local requester, frames it as an SS_n-low window on the shared clock, and shifts the {cmd, 10-bit payload} word out MSB-first on MOSI. For read-data commands it captures the 8-bit RAM response from MISO and returns it on a one-cycle response strobe. It also flags read-data requests issued without a preceding read-address.

## Interface
- RD_WAIT, 3: frame cycles between last MOSI payload bit and first MISO sample (covers slave rx_valid + RAM tx_valid + registered MISO).
- MIN_IDLE, 1: minimum cycles SS_n stays high between frames.

- clk  in  1  single clock; shared with slave (SCK == clk).
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  command request.
- req_ready  out  1  master can accept request this cycle.
- req_cmd  in  2  00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- req_data  in  8  address/data byte (ignored content for read-data, still shifted).
- SS_n  out  1  slave select, active-low, registered.
- MOSI  out  1  serial out, registered.
- MISO  in  1  serial in from slave.
- rd_data  out  8  captured read byte.
- rd_valid  out  1  one-cycle strobe, rd_data valid.
- seq_err  out  1  one-cycle strobe, read-data requested with no outstanding read-addr.

## Operation
- Accept: req_valid && req_ready at a rising edge latches {req_cmd, req_data} into 10-bit shift register; req_ready drops next cycle.
- States (mstate_t): IDLE, SEL, CMD, SHIFT, HOLD, WAIT_RD, CAPTURE, GAP.
- IDLE: SS_n=1, MOSI=0, req_ready=1. Accept -> SEL.
- SEL (frame cycle 0): SS_n=0, MOSI=0. -> CMD.
- CMD (cycle 1): MOSI=req_cmd[1]. -> SHIFT, bit counter=9.
- SHIFT (cycles 2..11): MOSI=shift[counter], counter decrements; at counter 0 -> HOLD for cmd 00/01/10, WAIT_RD for 11.
- HOLD (cycle 12): SS_n=0, MOSI=0 while slave raises rx_valid. -> GAP.
- WAIT_RD: RD_WAIT cycles, MOSI=0, SS_n=0. -> CAPTURE, counter=7.
- CAPTURE: sample MISO into rd_data[counter] for 8 cycles MSB-first; after bit 0 pulse rd_valid next cycle. -> GAP.
- GAP: SS_n=1, MOSI=0 for MIN_IDLE cycles. -> IDLE.
- Sequence tracking: addr_pending flag set on completed read-addr frame, cleared on completed read-data frame. Read-data request with addr_pending=0 is accepted (frame still sent) and seq_err pulses in the accept+1 cycle. Write frames do not touch addr_pending.
- Counters: bit counter 4 bits; wait counter $clog2(RD_WAIT+1) bits, min 1; gap counter $clog2(MIN_IDLE+1), min 1. No wrap: counters only load or decrement to 0.

## Timing
- Reset values: SS_n=1, MOSI=0, req_ready=0 during reset, 1 first cycle after release; rd_data=0, rd_valid=0, seq_err=0, addr_pending=0, state IDLE.
- Reset asserted mid-frame: SS_n goes 1 and MOSI 0 immediately (async), partial rd_data discarded (cleared), no rd_valid.
- Write/read-addr frame: SS_n low exactly 13 cycles. Read-data frame: 12+RD_WAIT+8 cycles (23 default).
- Request-to-request throughput: 13+MIN_IDLE+1 cycles for writes (15 default).
- rd_valid asserted one cycle after last MISO sample; rd_data held until next capture.
- req_valid while req_ready=0: ignored, requester must hold.
- MISO ignored outside CAPTURE.

## Structure
- shared_pkg gains: mstate_t enum (distinct from slave state_t), cmd constants CMD_WR_ADDR/CMD_WR_DATA/CMD_RD_ADDR/CMD_RD_DATA, FRAME_BITS=10.
- Single module, no sub-module; interface bundle spi_master_if with DUT/TB modports alongside SPI_slave_if.

## Test plan
- Reset then write-addr 0x3C: SS_n low 13 cycles, MOSI over cycles 1..11 = 0,0,0,0,0,1,1,1,1,0,0; slave rx_data=0x03C, rx_valid=1.
- Write-data 0xA5 after write-addr: MOSI payload 01_10100101; RAM location 0x3C holds 0xA5.
- Read-addr 0x3C then read-data: rd_valid pulses once with rd_data=0xA5, read frame SS_n low 23 cycles, seq_err never set.
- Read-data from reset with no read-addr: frame sent, seq_err pulses once, addr_pending stays 0.
- Back-to-back req_valid held high for two writes: second accept exactly 15 cycles after first; SS_n high ≥1 cycle between frames.
- rst_n low during SHIFT cycle 6: SS_n=1 same cycle, rd_valid stays 0, req_ready=1 after release, next write-addr 0x01 completes correctly.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI command master: state encoding,
// command codes and the latched {cmd, payload} frame word.
package spi_master_pkg;

    localparam int unsigned CMD_W      = 2;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FRAME_BITS = CMD_W + DATA_W;
    localparam int unsigned BIT_CNT_W  = 4;

    localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
    localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        CMD,
        SHIFT,
        HOLD,
        WAIT_RD,
        CAPTURE,
        GAP
    } mstate_t;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] data;
    } frame_t;

endpackage

// File: rtl/spi_master_if.sv
// Requester handshake, serial link and read-response signals of the SPI master.
interface spi_master_if;

    logic                              req_valid;
    logic                              req_ready;
    logic [spi_master_pkg::CMD_W-1:0]  req_cmd;
    logic [spi_master_pkg::DATA_W-1:0] req_data;
    logic                              SS_n;
    logic                              MOSI;
    logic                              MISO;
    logic [spi_master_pkg::DATA_W-1:0] rd_data;
    logic                              rd_valid;
    logic                              seq_err;

    modport master (
        input  req_valid, req_cmd, req_data, MISO,
        output req_ready, SS_n, MOSI, rd_data, rd_valid, seq_err
    );

    modport slave (
        output req_valid, req_cmd, req_data, MISO,
        input  req_ready, SS_n, MOSI, rd_data, rd_valid, seq_err
    );

endinterface

// File: rtl/spi_master.sv
// SPI command master: frames one {cmd, payload} word per request on SS_n/MOSI
// and, for read-data commands, captures the 8-bit response from MISO.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned RD_WAIT  = 3,
    parameter int unsigned MIN_IDLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.master bus
);

    localparam int unsigned WAIT_W = ($clog2(RD_WAIT + 1) > 1)  ? $clog2(RD_WAIT + 1)  : 1;
    localparam int unsigned GAP_W  = ($clog2(MIN_IDLE + 1) > 1) ? $clog2(MIN_IDLE + 1) : 1;

    mstate_t               state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    frame_t                frame_q, frame_d;
    logic [FRAME_BITS-1:0] frame_bits;
    logic [DATA_W-2:0]     cap_q, cap_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  seq_err_q, seq_err_d;
    logic                  addr_pending_q, addr_pending_d;
    logic                  req_ready_q, req_ready_d;
    logic                  ss_n_q, ss_n_d;
    logic                  mosi_q, mosi_d;

    // Next-state and next-output logic; pins are registered from the *_d values
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        frame_d        = frame_q;
        cap_d          = cap_q;
        rd_data_d      = rd_data_q;
        rd_valid_d     = 1'b0;
        seq_err_d      = 1'b0;
        addr_pending_d = addr_pending_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    frame_d   = '{cmd: bus.req_cmd, data: bus.req_data};
                    seq_err_d = (bus.req_cmd == CMD_RD_DATA) && !addr_pending_q;
                    state_d   = SEL;
                end
            end
            SEL: state_d = CMD;
            CMD: begin
                bit_cnt_d = BIT_CNT_W'(FRAME_BITS - 1);
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt_q == '0) begin
                    if (frame_q.cmd == CMD_RD_DATA) begin
                        wait_cnt_d = WAIT_W'(RD_WAIT - 1);
                        state_d    = WAIT_RD;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
                end
            end
            HOLD: begin
                if (frame_q.cmd == CMD_RD_ADDR) addr_pending_d = 1'b1;
                gap_cnt_d = GAP_W'(MIN_IDLE - 1);
                state_d   = GAP;
            end
            WAIT_RD: begin
                if (wait_cnt_q == '0) begin
                    bit_cnt_d = BIT_CNT_W'(DATA_W - 1);
                    state_d   = CAPTURE;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            CAPTURE: begin
                cap_d = {cap_q[DATA_W-3:0], bus.MISO};
                if (bit_cnt_q == '0) begin
                    rd_data_d      = {cap_q, bus.MISO};
                    rd_valid_d     = 1'b1;
                    addr_pending_d = 1'b0;
                    gap_cnt_d      = GAP_W'(MIN_IDLE - 1);
                    state_d        = GAP;
                end else begin
                    bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) state_d = IDLE;
                else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // MOSI repeats cmd[1] in the CMD slot, then walks the full 10-bit word
        frame_bits  = FRAME_BITS'(frame_d);
        ss_n_d      = (state_d == IDLE) || (state_d == GAP);
        req_ready_d = (state_d == IDLE);
        mosi_d      = 1'b0;
        if (state_d == CMD)        mosi_d = frame_bits[FRAME_BITS-1];
        else if (state_d == SHIFT) mosi_d = frame_bits[bit_cnt_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            wait_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            frame_q        <= '0;
            cap_q          <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            seq_err_q      <= 1'b0;
            addr_pending_q <= 1'b0;
            req_ready_q    <= 1'b0;
            ss_n_q         <= 1'b1;
            mosi_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            frame_q        <= frame_d;
            cap_q          <= cap_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            seq_err_q      <= seq_err_d;
            addr_pending_q <= addr_pending_d;
            req_ready_q    <= req_ready_d;
            ss_n_q         <= ss_n_d;
            mosi_q         <= mosi_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.SS_n      = ss_n_q;
    assign bus.MOSI      = mosi_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.seq_err   = seq_err_q;

endmodule
